iq_power_trigger: RTL and testbench
===================================

// Module: iq_power_trigger
// PURPOSE
//   Parametrised I/Q power trigger; successor to the single-channel |I| trigger.
//   Computes a selectable magnitude per valid sample and fires a one-cycle trigger
//   after N consecutive samples exceed a threshold. Adds cooldown and hysteresis re-arm.
//   Sits after the sample source and gates downstream capture/demod start.
// PARAMETERS
//   SAMPLE_W  16  width of each signed I and Q component
//   CNT_W     32  width of skip/cooldown counters and trig_count
//   QUAL_W    8   width of the qualify-count input
// PORTS
//   clock       in   1           single clock, rising edge
//   reset       in   1           asynchronous, active-high
//   enable      in   1           sample valid; state advances only on valid samples
//   sample      in   2*SAMPLE_W  {I[2W-1:W], Q[W-1:0]}, two's complement
//   mode        in   2           0:|I| 1:|Q| 2:|I|+|Q| 3:max(|I|,|Q|)
//   threshold   in   SAMPLE_W+1  trigger when mag > threshold (unsigned)
//   hysteresis  in   SAMPLE_W+1  re-arm level = threshold-hysteresis, saturating at 0
//   qualify     in   QUAL_W      consecutive above-threshold samples needed; 0 treated as 1
//   cooldown    in   CNT_W       valid samples ignored after a trigger
//   skip        in   CNT_W       valid samples discarded after reset
//   trigger     out  1           one-cycle pulse
//   armed       out  1           high while in ARMED
//   trig_count  out  CNT_W       triggers since reset, saturates at all-ones
//   peak_mag    out  SAMPLE_W+1  only with POWERTRIG_PEAK_HOLD_EN
// BEHAVIOUR
//   Reset (async, any time): state=SKIP; trigger, armed, trig_count, peak_mag,
//     counters and pipeline valid = 0. An in-flight sample is discarded.
//   Stage 1: on edge with enable=1, register mag (SAMPLE_W+1 bits, unsigned) and
//     set mag_vld=1; otherwise mag_vld=0. The FSM acts only when mag_vld=1.
//   Abs: -2^(W-1) -> 2^(W-1), exact. Sum mode max = 2^W, no overflow.
//   Latency: sample accepted at edge N -> trigger high for the cycle after edge N+1.
//   Config ports are read live and must be held static while running.
//   FSM (powertrig_pkg::state_t):
//     SKIP:     count valid samples; after `skip` discards go to ARMED.
//               skip=0 -> ARMED on first edge after reset release.
//     ARMED:    mag>thr -> qcnt++. If qcnt+1 >= max(qualify,1): trigger=1,
//               trig_count++, qcnt=0, go to COOLDOWN (or REARM if cooldown=0).
//               mag<=thr -> qcnt=0.
//     COOLDOWN: consume exactly `cooldown` valid samples, no compare, then REARM.
//     REARM:    mag <= sat(thr-hyst) -> ARMED. This sample is not evaluated
//               for trigger. hyst=0 re-arms on the first non-exceeding sample.
//   trigger drops on the next edge regardless of enable. armed is a registered state decode.
//   enable gaps stall the FSM and counters; they never reset qcnt.
// CONFIGURATION
//   POWERTRIG_PEAK_HOLD_EN defined: peak_mag holds the max mag from the first
//     above-threshold sample of the run through the last COOLDOWN sample.
//     It is cleared when that run starts and holds until the next run starts.
//   Not defined: the peak_mag port and its logic are absent. Other behaviour is identical.
// STRUCTURE
//   Package powertrig_pkg: state_t enum {SKIP, ARMED, COOLDOWN, REARM};
//     localparams MAG_ABS_I=0, MAG_ABS_Q=1, MAG_SUM=2, MAG_MAX=3.
//   Sub-module iq_magnitude #(SAMPLE_W): combinational abs/sum/max by mode.
//     The parent registers its output.
// TESTING
//   1 skip=3, thr=100, mode0, I=500 constant, enable=1: armed rises after 3 samples.
//     First trigger comes from sample 4, 2 cycles after it is accepted.
//   2 mode0 I=0x8000, thr=32767 -> trigger (mag 32768).
//     mode2 I=Q=0x8000, thr=65535 -> trigger (mag 65536).
//   3 qualify=3, thr=100, I seq 200,200,50,200,200,200 -> single trigger on sample 6.
//   4 thr=100, hyst=20, cooldown=2, seq 200,200,200,90,70,150: triggers on samples 1 and 6.
//     Samples 2-3 ignored; 90 keeps REARM; 70 re-arms; trig_count=2.
//   5 Repeat case 3 with enable toggling every cycle: same sample index triggers.
//     Async reset mid-COOLDOWN clears trigger/armed/trig_count before the next edge;
//     SKIP then restarts.
//   6 With POWERTRIG_PEAK_HOLD_EN, qualify=1, cooldown=2, seq 150,300,120 -> peak_mag=300.

Source files
------------

// File: rtl/powertrig_pkg.sv
//------------------------------------------------------------------------------
// Module   : powertrig_pkg
// Purpose  : Shared state encoding and magnitude-mode codes for the I/Q trigger.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package powertrig_pkg;

   typedef enum logic [1:0] {
      SKIP     = 2'd0,
      ARMED    = 2'd1,
      COOLDOWN = 2'd2,
      REARM    = 2'd3
   } state_t;

   localparam logic [1:0] MAG_ABS_I = 2'd0;
   localparam logic [1:0] MAG_ABS_Q = 2'd1;
   localparam logic [1:0] MAG_SUM   = 2'd2;
   localparam logic [1:0] MAG_MAX   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/iq_magnitude.sv
//------------------------------------------------------------------------------
// Module   : iq_magnitude
// Purpose  : Combinational |I|, |Q|, |I|+|Q| or max(|I|,|Q|) of a packed I/Q sample.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iq_magnitude
   import powertrig_pkg::*;
#(
   parameter int SAMPLE_W = 16
) (
   input  logic [2*SAMPLE_W-1:0] sample,
   input  logic [1:0]            mode,
   output logic [SAMPLE_W:0]     mag
);

   logic signed [SAMPLE_W:0] w_i_ext;
   logic signed [SAMPLE_W:0] w_q_ext;
   logic        [SAMPLE_W:0] w_abs_i;
   logic        [SAMPLE_W:0] w_abs_q;

   // One extra bit makes the most negative input negate exactly.
   assign w_i_ext = {sample[2*SAMPLE_W-1], sample[2*SAMPLE_W-1:SAMPLE_W]};
   assign w_q_ext = {sample[SAMPLE_W-1], sample[SAMPLE_W-1:0]};

   assign w_abs_i = w_i_ext[SAMPLE_W] ? $unsigned(-w_i_ext) : $unsigned(w_i_ext);
   assign w_abs_q = w_q_ext[SAMPLE_W] ? $unsigned(-w_q_ext) : $unsigned(w_q_ext);

   always_comb begin
      mag = w_abs_i;
      case (mode)
         MAG_ABS_I: mag = w_abs_i;
         MAG_ABS_Q: mag = w_abs_q;
         MAG_SUM:   mag = w_abs_i + w_abs_q;
         MAG_MAX:   mag = (w_abs_i >= w_abs_q) ? w_abs_i : w_abs_q;
         default:   mag = w_abs_i;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/iq_power_trigger.sv
//------------------------------------------------------------------------------
// Module   : iq_power_trigger
// Purpose  : Qualified I/Q magnitude trigger with skip, cooldown and hysteresis
//            re-arm. POWERTRIG_PEAK_HOLD_EN adds the peak_mag output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iq_power_trigger
   import powertrig_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int CNT_W    = 32,
   parameter int QUAL_W   = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [2*SAMPLE_W-1:0] sample,
   input  logic [1:0]            mode,
   input  logic [SAMPLE_W:0]     threshold,
   input  logic [SAMPLE_W:0]     hysteresis,
   input  logic [QUAL_W-1:0]     qualify,
   input  logic [CNT_W-1:0]      cooldown,
   input  logic [CNT_W-1:0]      skip,
   output logic                  trigger,
   output logic                  armed,
   output logic [CNT_W-1:0]      trig_count
`ifdef POWERTRIG_PEAK_HOLD_EN
   ,
   output logic [SAMPLE_W:0]     peak_mag
`endif
);

   logic [SAMPLE_W:0]  w_mag;
   logic [SAMPLE_W:0]  r_mag;
   logic               r_mag_vld;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [QUAL_W-1:0]  r_qcnt;
   logic [QUAL_W-1:0]  w_qcnt_nxt;
   logic               w_fire;

   logic [CNT_W:0]     w_cnt_inc;
   logic [QUAL_W:0]    w_qcnt_inc;
   logic [QUAL_W-1:0]  w_qual_need;
   logic [SAMPLE_W:0]  w_rearm_lvl;
   logic               w_above;
   logic               w_qual_hit;
   logic               w_skip_done;
   logic               w_cool_done;
   logic               w_rearm_ok;

   iq_magnitude #(
      .SAMPLE_W (SAMPLE_W)
   ) u_mag (
      .sample (sample),
      .mode   (mode),
      .mag    (w_mag)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mag     <= '0;
         r_mag_vld <= 1'b0;
      end else begin
         r_mag_vld <= enable;
         if (enable) begin
            r_mag <= w_mag;
         end
      end
   end

   assign w_cnt_inc   = {1'b0, r_cnt} + (CNT_W+1)'(1);
   assign w_qcnt_inc  = {1'b0, r_qcnt} + (QUAL_W+1)'(1);
   assign w_qual_need = (qualify == '0) ? QUAL_W'(1) : qualify;
   assign w_rearm_lvl = (threshold > hysteresis) ? (threshold - hysteresis) : '0;
   assign w_above     = (r_mag > threshold);
   assign w_qual_hit  = (w_qcnt_inc >= {1'b0, w_qual_need});
   assign w_skip_done = (w_cnt_inc >= {1'b0, skip});
   assign w_cool_done = (w_cnt_inc >= {1'b0, cooldown});
   assign w_rearm_ok  = (r_mag <= w_rearm_lvl);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= SKIP;
         r_cnt   <= '0;
         r_qcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_qcnt  <= w_qcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SKIP: begin
            // A zero skip arms on the first edge even without a valid sample.
            if (skip == '0) begin
               w_state_nxt = ARMED;
            end else if (r_mag_vld && w_skip_done) begin
               w_state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (r_mag_vld && w_above && w_qual_hit) begin
               w_state_nxt = (cooldown == '0) ? REARM : COOLDOWN;
            end
         end
         COOLDOWN: begin
            if (r_mag_vld && w_cool_done) begin
               w_state_nxt = REARM;
            end
         end
         REARM: begin
            if (r_mag_vld && w_rearm_ok) begin
               w_state_nxt = ARMED;
            end
         end
         default: w_state_nxt = SKIP;
      endcase
   end

   always_comb begin
      w_fire     = 1'b0;
      w_cnt_nxt  = r_cnt;
      w_qcnt_nxt = r_qcnt;
      case (r_state)
         SKIP: begin
            if (r_mag_vld && (skip != '0)) begin
               w_cnt_nxt = w_skip_done ? '0 : w_cnt_inc[CNT_W-1:0];
            end
         end
         ARMED: begin
            if (r_mag_vld) begin
               if (w_above) begin
                  if (w_qual_hit) begin
                     w_fire     = 1'b1;
                     w_qcnt_nxt = '0;
                  end else begin
                     w_qcnt_nxt = w_qcnt_inc[QUAL_W-1:0];
                  end
               end else begin
                  w_qcnt_nxt = '0;
               end
            end
         end
         COOLDOWN: begin
            if (r_mag_vld) begin
               w_cnt_nxt = w_cool_done ? '0 : w_cnt_inc[CNT_W-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         trigger    <= 1'b0;
         armed      <= 1'b0;
         trig_count <= '0;
      end else begin
         trigger <= w_fire;
         armed   <= (w_state_nxt == ARMED);
         if (w_fire && (trig_count != '1)) begin
            trig_count <= trig_count + CNT_W'(1);
         end
      end
   end

`ifdef POWERTRIG_PEAK_HOLD_EN
   logic w_run_start;
   logic w_peak_upd;

   // A run begins with the first above-threshold sample seen while ARMED.
   always_comb begin
      w_run_start = 1'b0;
      w_peak_upd  = 1'b0;
      if (r_mag_vld) begin
         if ((r_state == ARMED) && w_above) begin
            w_run_start = (r_qcnt == '0);
            w_peak_upd  = 1'b1;
         end else if (r_state == COOLDOWN) begin
            w_peak_upd  = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         peak_mag <= '0;
      end else if (w_run_start) begin
         peak_mag <= r_mag;
      end else if (w_peak_upd && (r_mag > peak_mag)) begin
         peak_mag <= r_mag;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_iq_power_trigger.sv
//------------------------------------------------------------------------------
// Module   : tb_iq_power_trigger
// Purpose  : Self-checking bench for iq_power_trigger: directed vector table,
//            multi-cycle sequences and randomized episodes against a model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iq_power_trigger;

   localparam int SAMPLE_W = 16;
   localparam int CNT_W    = 32;
   localparam int QUAL_W   = 8;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic                  enable = 1'b0;
   logic [2*SAMPLE_W-1:0] sample = '0;
   logic [1:0]            mode = '0;
   logic [SAMPLE_W:0]     threshold = '0;
   logic [SAMPLE_W:0]     hysteresis = '0;
   logic [QUAL_W-1:0]     qualify = '0;
   logic [CNT_W-1:0]      cooldown = '0;
   logic [CNT_W-1:0]      skip = '0;
   logic                  trigger;
   logic                  armed;
   logic [CNT_W-1:0]      trig_count;
`ifdef POWERTRIG_PEAK_HOLD_EN
   logic [SAMPLE_W:0]     peak_mag;
`endif

   iq_power_trigger #(
      .SAMPLE_W (SAMPLE_W),
      .CNT_W    (CNT_W),
      .QUAL_W   (QUAL_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .sample     (sample),
      .mode       (mode),
      .threshold  (threshold),
      .hysteresis (hysteresis),
      .qualify    (qualify),
      .cooldown   (cooldown),
      .skip       (skip),
      .trigger    (trigger),
      .armed      (armed),
      .trig_count (trig_count)
`ifdef POWERTRIG_PEAK_HOLD_EN
      ,
      .peak_mag   (peak_mag)
`endif
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0]       skp;
      logic [7:0]        qual;
      logic [16:0]       thr;
      logic [16:0]       hyst;
      logic [31:0]       cd;
      logic [1:0]        md;
      logic              gap;
      logic [3:0]        n;
      logic [7:0][31:0]  smp;
      logic [7:0]        exp_mask;
      logic [31:0]       exp_cnt;
   } vec_t;

   vec_t vecs[$];
   int   ai[8];
   int   aq[8];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] iq(input int i, input int q);
      logic [31:0] r;
      r = {i[15:0], q[15:0]};
      return r;
   endfunction

   task automatic add(input int skp, input int q, input int th, input int hy, input int c,
                      input int md, input int gp, input int n, input int mask, input int cnt);
      vec_t v;
      v          = '0;
      v.skp      = skp;
      v.qual     = q[7:0];
      v.thr      = th[16:0];
      v.hyst     = hy[16:0];
      v.cd       = c;
      v.md       = md[1:0];
      v.gap      = gp[0];
      v.n        = n[3:0];
      v.exp_mask = mask[7:0];
      v.exp_cnt  = cnt;
      for (int k = 0; k < 8; k++) v.smp[k] = iq(ai[k], aq[k]);
      vecs.push_back(v);
   endtask

   // ---------------- reference model (sample-level, spec rules) -------------
   int     m_phase;      // 0 skip, 1 armed, 2 cooldown, 3 rearm
   int     m_skip_left;
   int     m_cool_left;
   int     m_run;
   int     m_peak;
   longint m_count;
   bit     m_trig;
   bit     p_vld;
   int     p_mag;

   function automatic int ref_mag(input logic [31:0] s, input logic [1:0] md);
      int i, q, a, b;
      i = int'($signed(s[31:16]));
      q = int'($signed(s[15:0]));
      a = (i < 0) ? -i : i;
      b = (q < 0) ? -q : q;
      case (md)
         2'd0:    return a;
         2'd1:    return b;
         2'd2:    return a + b;
         default: return (a > b) ? a : b;
      endcase
   endfunction

   task automatic model_reset();
      m_phase = 0; m_skip_left = int'(skip); m_cool_left = 0;
      m_run = 0; m_peak = 0; m_count = 0; m_trig = 0; p_vld = 0; p_mag = 0;
   endtask

   task automatic model_edge();
      int th, lvl, qneed;
      th    = int'(threshold);
      lvl   = (int'(threshold) > int'(hysteresis)) ? th - int'(hysteresis) : 0;
      qneed = (qualify == 0) ? 1 : int'(qualify);
      m_trig = 0;
      case (m_phase)
         0: begin
            if (m_skip_left == 0) m_phase = 1;
            else if (p_vld) begin
               m_skip_left--;
               if (m_skip_left == 0) m_phase = 1;
            end
         end
         1: if (p_vld) begin
            if (p_mag > th) begin
               m_peak = (m_run == 0) ? p_mag : ((p_mag > m_peak) ? p_mag : m_peak);
               m_run++;
               if (m_run >= qneed) begin
                  m_trig = 1;
                  if (m_count < 64'hFFFF_FFFF) m_count++;
                  m_run = 0;
                  m_cool_left = int'(cooldown);
                  m_phase = (m_cool_left == 0) ? 3 : 2;
               end
            end else m_run = 0;
         end
         2: if (p_vld) begin
            if (p_mag > m_peak) m_peak = p_mag;
            m_cool_left--;
            if (m_cool_left == 0) m_phase = 3;
         end
         default: if (p_vld && p_mag <= lvl) m_phase = 1;
      endcase
      p_vld = enable;
      p_mag = ref_mag(sample, mode);
   endtask

   // ---------------- stimulus helpers ----------------------------------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b0;
      @(posedge clock);
      #1;
      check("reset trigger", 64'(trigger), 64'd0);
      check("reset armed", 64'(armed), 64'd0);
      check("reset trig_count", 64'(trig_count), 64'd0);
`ifdef POWERTRIG_PEAK_HOLD_EN
      check("reset peak_mag", 64'(peak_mag), 64'd0);
`endif
      reset = 1'b0;
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      logic [8:0] obs;
      int         prev;
      skip = v.skp; qualify = v.qual; threshold = v.thr; hysteresis = v.hyst;
      cooldown = v.cd; mode = v.md;
      do_reset();
      obs  = '0;
      prev = -1;
      for (int k = 0; k < 8 + 8 + 3; k++) begin
         int idx;
         idx = -1;
         if (k < 2 * int'(v.n) && (v.gap || k < int'(v.n))) begin
            if (v.gap) begin
               enable = (k % 2 == 0);
               idx    = (k % 2 == 0) ? k / 2 : -1;
               sample = v.smp[k / 2];
            end else begin
               enable = 1'b1;
               idx    = k;
               sample = v.smp[k];
            end
         end else begin
            enable = 1'b0;
         end
         tick();
         if (trigger === 1'b1) begin
            if (prev >= 0) obs[prev] = 1'b1;
            else obs[8] = 1'b1;
         end
         prev = idx;
      end
      check($sformatf("vec%0d trigger mask", vi), 64'(obs), 64'({1'b0, v.exp_mask}));
      check($sformatf("vec%0d trig_count", vi), 64'(trig_count), 64'(v.exp_cnt));
   endtask

   task automatic cfg(input int skp, input int q, input int th, input int hy, input int c, input int md);
      skip = skp; qualify = q[7:0]; threshold = th[16:0]; hysteresis = hy[16:0];
      cooldown = c; mode = md[1:0];
   endtask

   initial begin
      // ---------------- directed vector table ----------------
      aq = '{default: 0};
      ai = '{500, 500, 500, 500, 500, 500, 0, 0};
      add(3, 1, 100, 0, 0, 0, 0, 6, 8'h08, 1);
      ai = '{-32768, -32768, 0, 0, 0, 0, 0, 0};
      add(0, 1, 32767, 0, 0, 0, 0, 2, 8'h01, 1);
      aq = '{-32768, 0, 0, 0, 0, 0, 0, 0};
      add(0, 1, 65535, 0, 0, 2, 0, 1, 8'h01, 1);
      add(0, 1, 65536, 0, 0, 2, 0, 1, 8'h00, 0);
      ai = '{-300, 0, 0, 0, 0, 0, 0, 0};
      aq = '{200, 0, 0, 0, 0, 0, 0, 0};
      add(0, 1, 299, 0, 0, 3, 0, 1, 8'h01, 1);
      add(0, 1, 300, 0, 0, 3, 0, 1, 8'h00, 0);
      ai = '{5000, 0, 0, 0, 0, 0, 0, 0};
      aq = '{50, -101, 0, 0, 0, 0, 0, 0};
      add(0, 1, 100, 0, 0, 1, 0, 2, 8'h02, 1);
      ai = '{-60, 0, 0, 0, 0, 0, 0, 0};
      aq = '{50, 0, 0, 0, 0, 0, 0, 0};
      add(0, 1, 109, 0, 0, 2, 0, 1, 8'h01, 1);
      aq = '{default: 0};
      ai = '{100, 101, 0, 0, 0, 0, 0, 0};
      add(0, 1, 100, 0, 0, 0, 0, 2, 8'h02, 1);
      ai = '{200, 200, 50, 200, 200, 200, 0, 0};
      add(0, 3, 100, 0, 0, 0, 0, 6, 8'h20, 1);
      add(0, 3, 100, 0, 0, 0, 1, 6, 8'h20, 1);
      ai = '{200, 200, 200, 90, 70, 150, 0, 0};
      add(0, 1, 100, 20, 2, 0, 0, 6, 8'h21, 2);
      ai = '{20, 5, 0, 20, 0, 0, 0, 0};
      add(0, 1, 10, 50, 0, 0, 0, 4, 8'h09, 2);
      ai = '{50, 150, 0, 0, 0, 0, 0, 0};
      add(0, 0, 100, 0, 0, 0, 0, 2, 8'h02, 1);

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // ---------------- skip / armed / latency sequence ----------------
      cfg(3, 1, 100, 0, 0, 0);
      do_reset();
      enable = 1'b1;
      sample = iq(500, 0);
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 3) check("skip armed low after edge 3", 64'(armed), 64'd0);
         if (e == 4) check("skip armed high after edge 4", 64'(armed), 64'd1);
         if (e == 4) check("latency trigger low after edge 4", 64'(trigger), 64'd0);
         if (e == 5) check("latency trigger high after edge 5", 64'(trigger), 64'd1);
         if (e == 6) check("trigger one-cycle pulse", 64'(trigger), 64'd0);
      end
      check("skip seq trig_count", 64'(trig_count), 64'd1);
      enable = 1'b0;

      // ---------------- async reset in COOLDOWN, then SKIP restarts ----------
      cfg(0, 1, 100, 0, 5, 0);
      do_reset();
      enable = 1'b1;
      sample = iq(200, 0);
      tick();
      tick();
      check("pre-reset trigger", 64'(trigger), 64'd1);
      check("pre-reset trig_count", 64'(trig_count), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("async reset trigger", 64'(trigger), 64'd0);
      check("async reset armed", 64'(armed), 64'd0);
      check("async reset trig_count", 64'(trig_count), 64'd0);
      skip = 2;
      sample = iq(500, 0);
      tick();
      reset = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick();
         if (e == 2) check("restart armed low", 64'(armed), 64'd0);
         if (e == 3) check("restart armed high", 64'(armed), 64'd1);
         if (e == 4) check("restart trigger", 64'(trigger), 64'd1);
      end
      enable = 1'b0;

`ifdef POWERTRIG_PEAK_HOLD_EN
      // ---------------- peak hold across a run ----------------
      cfg(0, 1, 100, 0, 2, 0);
      do_reset();
      ai = '{150, 300, 120, 50, 180, 0, 0, 0};
      for (int k = 0; k < 8; k++) begin
         enable = (k < 5);
         sample = iq(ai[k % 8], 0);
         tick();
         if (k == 4) check("peak after cooldown", 64'(peak_mag), 64'd300);
      end
      check("peak new run", 64'(peak_mag), 64'd180);
`endif

      // ---------------- randomized episodes vs model ----------------
      for (int ep = 0; ep < 8; ep++) begin
         cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3000),
             $urandom_range(0, 1500), $urandom_range(0, 4), $urandom_range(0, 3));
         do_reset();
         model_reset();
         for (int c = 0; c < 250; c++) begin
            int si, sq;
            enable = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) begin
               si = ($urandom_range(0, 1) == 1) ? -32768 : 32767;
               sq = ($urandom_range(0, 1) == 1) ? -32768 : 32767;
            end else begin
               si = int'($urandom_range(0, 5000)) - 2500;
               sq = int'($urandom_range(0, 5000)) - 2500;
            end
            sample = iq(si, sq);
            @(posedge clock);
            model_edge();
            #1;
            check($sformatf("rand ep%0d c%0d trigger", ep, c), 64'(trigger), 64'(m_trig));
            check($sformatf("rand ep%0d c%0d armed", ep, c), 64'(armed), 64'(m_phase == 1));
            check($sformatf("rand ep%0d c%0d trig_count", ep, c), 64'(trig_count), 64'(m_count));
`ifdef POWERTRIG_PEAK_HOLD_EN
            check($sformatf("rand ep%0d c%0d peak_mag", ep, c), 64'(peak_mag), 64'(m_peak));
`endif
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
